// File: rtl/inst_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_assembler_pkg
// Description : Shared definitions for the instruction assembler: format
//               codes, RV32I opcodes, error codes, immediate range limits
//               and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_assembler_pkg;

  // Instruction format selectors (in_fmt); 6 and 7 are illegal
  localparam logic [2:0] C_FMT_IALU   = 3'd0;
  localparam logic [2:0] C_FMT_LOAD   = 3'd1;
  localparam logic [2:0] C_FMT_STORE  = 3'd2;
  localparam logic [2:0] C_FMT_BRANCH = 3'd3;
  localparam logic [2:0] C_FMT_JAL    = 3'd4;
  localparam logic [2:0] C_FMT_JALR   = 3'd5;

  // Major opcodes, one per format
  localparam logic [6:0] C_OP_IALU   = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;

  // err_code values
  localparam logic [1:0] C_ERR_NONE    = 2'd0;
  localparam logic [1:0] C_ERR_RANGE   = 2'd1;
  localparam logic [1:0] C_ERR_ALIGN   = 2'd2;
  localparam logic [1:0] C_ERR_BAD_FMT = 2'd3;

  // Signed immediate limits (byte offsets)
  localparam int C_IMM12_MIN  = -2048;
  localparam int C_IMM12_MAX  = 2047;
  localparam int C_IMM_BR_MIN = -4096;
  localparam int C_IMM_BR_MAX = 4094;
  localparam int C_IMM_J_MIN  = -1048576;
  localparam int C_IMM_J_MAX  = 1048574;
  localparam int C_SHAMT_MIN  = 0;
  localparam int C_SHAMT_MAX  = 31;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  // Immediate shifts are the only I-ALU forms that carry funct7
  function automatic logic is_shift(input logic [2:0] fmt, input logic [2:0] funct3);
    return (fmt == C_FMT_IALU) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_assembler_pack.sv
`default_nettype none
// ============================================================================
// Module      : inst_pack
// Description : Combinational encoder. Packs instruction fields into a
//               32-bit RV32I word and classifies the request.
// Ports       : fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i (fields)
//               word_o (packed word), illegal_o, code_o (prioritised error)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_pack
  import inst_assembler_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic [1:0]  code_o
);

  logic signed [31:0] w_imm_s;
  logic               w_fmt_ok;
  logic               w_range_ok;
  logic               w_align_ok;

  assign w_imm_s = $signed(imm_i);

  always_comb begin
    word_o     = '0;
    w_fmt_ok   = 1'b1;
    w_range_ok = 1'b1;
    w_align_ok = 1'b1;

    case (fmt_i)
      C_FMT_IALU: begin
        if (is_shift(fmt_i, funct3_i)) begin
          w_range_ok = (w_imm_s >= C_SHAMT_MIN) && (w_imm_s <= C_SHAMT_MAX);
          word_o     = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, C_OP_IALU};
        end else begin
          w_range_ok = (w_imm_s >= C_IMM12_MIN) && (w_imm_s <= C_IMM12_MAX);
          word_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, C_OP_IALU};
        end
      end
      C_FMT_LOAD: begin
        w_range_ok = (w_imm_s >= C_IMM12_MIN) && (w_imm_s <= C_IMM12_MAX);
        word_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, C_OP_LOAD};
      end
      C_FMT_JALR: begin
        w_range_ok = (w_imm_s >= C_IMM12_MIN) && (w_imm_s <= C_IMM12_MAX);
        word_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, C_OP_JALR};
      end
      C_FMT_STORE: begin
        w_range_ok = (w_imm_s >= C_IMM12_MIN) && (w_imm_s <= C_IMM12_MAX);
        word_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], C_OP_STORE};
      end
      C_FMT_BRANCH: begin
        w_range_ok = (w_imm_s >= C_IMM_BR_MIN) && (w_imm_s <= C_IMM_BR_MAX);
        w_align_ok = ~imm_i[0];
        word_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], C_OP_BRANCH};
      end
      C_FMT_JAL: begin
        w_range_ok = (w_imm_s >= C_IMM_J_MIN) && (w_imm_s <= C_IMM_J_MAX);
        w_align_ok = ~imm_i[0];
        word_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, C_OP_JAL};
      end
      default: begin
        w_fmt_ok = 1'b0;
      end
    endcase
  end

  // Priority: bad format, then range, then alignment
  always_comb begin
    code_o = C_ERR_NONE;
    if (!w_fmt_ok) begin
      code_o = C_ERR_BAD_FMT;
    end else if (!w_range_ok) begin
      code_o = C_ERR_RANGE;
    end else if (!w_align_ok) begin
      code_o = C_ERR_ALIGN;
    end
  end

  assign illegal_o = (code_o != C_ERR_NONE);

endmodule
`default_nettype wire

// File: rtl/inst_assembler.sv
`default_nettype none
// ============================================================================
// Module      : inst_assembler
// Description : Accepts instruction fields, encodes them into RV32I words
//               and streams them into instruction memory at consecutive
//               word addresses starting from a loadable base.
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready + in_fmt/in_rd/in_rs1/in_rs2/in_funct3/
//               in_funct7/in_imm : field request handshake
//               load_start/load_base : set write pointer, clear status
//               mem_we/mem_addr/mem_wdata/mem_ready : memory write port
//               err/err_code : sticky first-error status
//               word_count   : words written since last load_start/reset
// Revision    : 1.0 - initial release
// ============================================================================
module inst_assembler
  import inst_assembler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        load_start,
  input  logic [31:0] load_base,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic [31:0] w_word;
  logic        w_illegal;
  logic [1:0]  w_code;
  logic        w_accept;

  inst_pack u_pack (
    .fmt_i     (in_fmt),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .funct3_i  (in_funct3),
    .funct7_i  (in_funct7),
    .imm_i     (in_imm),
    .word_o    (w_word),
    .illegal_o (w_illegal),
    .code_o    (w_code)
  );

  // rst is included so in_ready is low for the whole reset pulse
  assign in_ready = (state_q == S_IDLE) && !load_start && !rst;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;

    if (load_start) begin
      // Abort anything in flight; wdata keeps its last value
      state_d = S_IDLE;
      addr_d  = load_base;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = C_ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_illegal) begin
              wdata_d = w_word;
              state_d = S_WRITE;
            end else if (!err_q) begin
              // Only the first error is recorded
              err_d  = 1'b1;
              code_d = w_code;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            addr_d  = addr_q + 32'd4;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= C_ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_assembler
// Description : Self-checking bench for inst_assembler. Directed scenarios
//               followed by random requests compared with a behavioural
//               model of the encoding rules and the write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        load_start;
  logic [31:0] load_base;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  inst_assembler dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .load_start (load_start),
    .load_base  (load_base),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state
  int unsigned m_addr  = 0;
  int unsigned m_wdata = 0;
  int unsigned m_count = 0;
  int unsigned m_err   = 0;
  int unsigned m_code  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from the format tables with plain arithmetic
  function automatic void ref_encode(input int fmt, input int unsigned rd, input int unsigned rs1,
                                     input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                                     input longint imm, output int unsigned word, output int unsigned code);
    int unsigned ops[6] = '{32'h13, 32'h03, 32'h23, 32'h63, 32'h6F, 32'h67};
    longint lo, hi;
    int unsigned u;
    bit shift;
    u     = imm[31:0];
    shift = (fmt == 0) && (f3 == 1 || f3 == 5);
    word  = 0;
    code  = 0;
    if (fmt > 5) begin
      code = 3;
      return;
    end
    case (fmt)
      0:       begin lo = shift ? 0 : -2048; hi = shift ? 31 : 2047; end
      3:       begin lo = -4096;    hi = 4094;    end
      4:       begin lo = -1048576; hi = 1048574; end
      default: begin lo = -2048;    hi = 2047;    end
    endcase
    if (imm < lo || imm > hi)                            code = 1;
    else if ((fmt == 3 || fmt == 4) && (imm % 2 != 0))   code = 2;
    case (fmt)
      2: word = ((u >> 5) & 32'h7F) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
                | (u & 32'h1F) << 7 | ops[fmt];
      3: word = ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3F) << 25 | rs2 << 20 | rs1 << 15
                | f3 << 12 | ((u >> 1) & 32'hF) << 8 | ((u >> 11) & 1) << 7 | ops[fmt];
      4: word = ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3FF) << 21 | ((u >> 11) & 1) << 20
                | ((u >> 12) & 32'hFF) << 12 | rd << 7 | ops[fmt];
      default: begin
        if (shift) word = f7 << 25 | (u & 32'h1F) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | ops[fmt];
        else       word = (u & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | ops[fmt];
      end
    endcase
  endfunction

  task automatic drive_fields(input int fmt, input int unsigned rd, input int unsigned rs1,
                              input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                              input longint imm);
    in_fmt    = fmt[2:0];
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_funct3 = f3[2:0];
    in_funct7 = f7[6:0];
    in_imm    = imm[31:0];
  endtask

  // One full request: accept, optional back-pressure, completion
  task automatic send(input int fmt, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                      input longint imm, input int delay);
    int unsigned w, code;
    ref_encode(fmt, rd, rs1, rs2, f3, f7, imm, w, code);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    drive_fields(fmt, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (code == 0) begin
      m_wdata = w;
      check("we_after_accept", mem_we, 1);
      check("addr_write", mem_addr, m_addr);
      check("wdata", mem_wdata, w);
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("we_hold", mem_we, 1);
        check("wdata_hold", mem_wdata, w);
        check("addr_hold", mem_addr, m_addr);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      m_addr = m_addr + 4;
      if (m_count != 32'hFFFF) m_count++;
      check("we_done", mem_we, 0);
      check("addr_adv", mem_addr, m_addr);
      check("count", word_count, m_count);
    end else begin
      if (m_err == 0) begin
        m_err  = 1;
        m_code = code;
      end
      check("we_illegal", mem_we, 0);
      check("err", err, m_err);
      check("err_code", err_code, m_code);
      check("addr_illegal", mem_addr, m_addr);
      check("count_illegal", word_count, m_count);
      check("wdata_kept", mem_wdata, m_wdata);
    end
  endtask

  task automatic do_load(input logic [31:0] base);
    @(negedge clk);
    load_start = 1'b1;
    load_base  = base;
    #1;
    check("in_ready_load", in_ready, 0);
    @(negedge clk);
    load_start = 1'b0;
    m_addr  = base;
    m_count = 0;
    m_err   = 0;
    m_code  = 0;
    check("load_we", mem_we, 0);
    check("load_addr", mem_addr, m_addr);
    check("load_count", word_count, 0);
    check("load_err", err, 0);
    check("load_code", err_code, 0);
  endtask

  initial begin
    longint vals[20] = '{-1048577, -1048576, -4097, -4096, -2049, -2048, -1, 0, 1, 3,
                         31, 32, 2047, 2048, 4094, 4095, 4096, 1048574, 1048575, 1048576};
    longint imm;
    rst = 1'b1; in_valid = 0; load_start = 0; load_base = 0; mem_ready = 0;
    drive_fields(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", word_count, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Known encodings
    do_load(32'h100);
    send(0, 1, 0, 0, 0, 0, 5, 0);
    check("wdata_addi", mem_wdata, 32'h0050_0093);
    check("count_one", word_count, 1);
    send(3, 0, 1, 2, 0, 0, -8, 0);
    check("wdata_branch", mem_wdata, 32'hFE20_8CE3);
    send(4, 1, 0, 0, 0, 0, 2048, 1);
    check("wdata_jal", mem_wdata, 32'h0010_00EF);
    send(2, 0, 2, 5, 2, 0, 12, 3);
    check("wdata_store", mem_wdata, 32'h0051_2623);

    // Sticky first error
    send(3, 0, 1, 2, 0, 0, 3, 0);
    send(0, 1, 0, 0, 0, 0, 4096, 0);
    check("err_code_sticky", err_code, 2);
    send(6, 1, 1, 1, 0, 0, 0, 0);

    // Boundaries per format, including shift immediates
    do_load(32'h400);
    send(0, 3, 4, 0, 1, 7'h20, 31, 0);
    send(0, 3, 4, 0, 5, 7'h20, 32, 0);
    do_load(32'h400);
    send(1, 2, 3, 0, 2, 0, -2048, 0);
    send(5, 2, 3, 0, 0, 0, 2047, 0);
    send(3, 0, 1, 2, 1, 0, 4094, 0);
    send(3, 0, 1, 2, 1, 0, -4096, 0);
    send(4, 5, 0, 0, 0, 0, 1048574, 0);
    send(4, 5, 0, 0, 0, 0, -1048576, 0);
    send(4, 5, 0, 0, 0, 0, 1048576, 0);
    check("jal_range_code", err_code, 1);

    // load_start during WRITE aborts the word
    do_load(32'h80);
    @(negedge clk);
    drive_fields(0, 1, 0, 0, 0, 0, 5);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_we_before", mem_we, 1);
    do_load(32'h200);
    check("abort_addr", mem_addr, 32'h200);

    // load_start beats a simultaneous request
    @(negedge clk);
    drive_fields(0, 1, 0, 0, 0, 0, 7);
    in_valid = 1'b1; load_start = 1'b1; load_base = 32'h300;
    @(negedge clk);
    in_valid = 1'b0; load_start = 1'b0;
    m_addr = 32'h300; m_count = 0; m_err = 0; m_code = 0;
    check("race_we", mem_we, 0);
    check("race_addr", mem_addr, 32'h300);
    @(negedge clk);
    check("race_we_later", mem_we, 0);

    // Address wrap
    do_load(32'hFFFF_FFFC);
    send(0, 1, 0, 0, 0, 0, 1, 0);
    check("wrap_addr", mem_addr, 0);
    send(0, 1, 0, 0, 0, 0, 2, 0);

    // Reset during WRITE drops the word
    @(negedge clk);
    drive_fields(1, 1, 2, 0, 2, 0, 8);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_write_we_before", mem_we, 1);
    rst = 1'b1;
    #1;
    check("rst_write_we", mem_we, 0);
    check("rst_write_addr", mem_addr, 0);
    check("rst_write_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    m_addr = 0; m_count = 0; m_err = 0; m_code = 0; m_wdata = 0;
    @(negedge clk);
    check("rst_write_after", mem_we, 0);

    // Random requests
    for (int n = 0; n < 80; n++) begin
      if (n % 10 == 0) do_load($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 1) == 0) imm = vals[$urandom_range(0, 19)];
      else                           imm = longint'($urandom_range(0, 200)) - 100;
      send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
           imm, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_assembler.md
INST_ASSEMBLER -- requirements
Module: inst_assembler

Interface
REQ-001 SHALL have these ports: clk, input, 1, the single clock, all state on its rising edge.
REQ-002 SHALL have: rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have: in_valid, input, 1, instruction fields valid.
REQ-004 SHALL have: in_ready, output, 1, block can accept fields.
REQ-005 SHALL have: in_fmt, input, 3; 0=I-ALU, 1=LOAD, 2=STORE, 3=BRANCH, 4=JAL, 5=JALR, 6-7 illegal.
REQ-006 SHALL have: in_rd, in_rs1 and in_rs2, input, 5 each, register indices.
REQ-007 SHALL have: in_funct3, input, 3; in_funct7, input, 7, used for I-ALU shifts only (inst[31:25]=funct7 when funct3 is 001 or 101).
REQ-008 SHALL have: in_imm, input, 32, signed byte-offset or immediate.
REQ-009 SHALL have: load_start, input, 1; load_base, input, 32; a pulse that sets the write address.
REQ-010 SHALL have: mem_we, output, 1; mem_addr, output, 32; mem_wdata, output, 32; instruction-memory write port.
REQ-011 SHALL have: mem_ready, input, 1, memory accepts the write this cycle.
REQ-012 SHALL have: err, output, 1, sticky; err_code, output, 2; 1=imm out of range, 2=imm misaligned, 3=illegal fmt.
REQ-013 SHALL have: word_count, output, 16, number of words written.

Function
REQ-014 SHALL be a two-state FSM: IDLE and WRITE.
REQ-015 SHALL drive in_ready=1 only in IDLE with load_start=0.
REQ-016 On in_valid&&in_ready, SHALL encode the fields in the same edge into a registered word and go to WRITE if legal, otherwise stay in IDLE.
REQ-017 SHALL use opcodes 0010011, 0000011, 0100011, 1100011, 1101111 and 1100111 for fmt 0-5 respectively.
REQ-018 SHALL use these bit layouts: I/LOAD/JALR {imm[11:0],rs1,f3,rd,op}; STORE {imm[11:5],rs2,rs1,f3,imm[4:0],op}; BRANCH {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-019 SHALL apply these legal ranges: I/LOAD/STORE/JALR -2048..2047; BRANCH -4096..4094; JAL -1048576..1048574.
REQ-020 SHALL require bit 0 of the immediate to be 0 for BRANCH and JAL.
REQ-021 SHALL require the shift-immediate, when the I-ALU shift rule applies, to be 0..31; otherwise the result is code 1.
REQ-022 SHALL check error priority as: illegal fmt (3), then range (1), then alignment (2).
REQ-023 On an illegal request, SHALL write nothing, set err=1 and latch err_code (first error only), and leave the address and count unchanged.
REQ-024 In WRITE, SHALL hold mem_we=1 with stable mem_addr and mem_wdata until mem_ready=1.
REQ-025 At the mem_ready edge, SHALL advance mem_addr by 4 (wrapping modulo 2^32), increment word_count (saturating at 0xFFFF), and return to IDLE.
REQ-026 Latency: an accepted legal request SHALL produce mem_we=1 in the next cycle; peak throughput is one word per two cycles.
REQ-027 load_start in any state SHALL abort any pending write, set mem_addr=load_base, and clear word_count, err and err_code.
REQ-028 On load_start, SHALL set the state to IDLE and mem_we=0 in the following cycle.
REQ-029 load_start SHALL win over a simultaneous in_valid; that request is not accepted.
REQ-030 While mem_we=0, mem_wdata SHALL hold its last value.

Reset
REQ-031 rst SHALL asynchronously force: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, err=0, err_code=0.
REQ-032 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst is released.
REQ-033 rst during WRITE SHALL drop the pending word.

Structure
REQ-034 A shared package SHALL hold: the fmt codes, the six opcodes, the err_code values, and the immediate range limits.
REQ-035 SHALL contain one combinational sub-module, inst_pack, that takes the fields and returns the packed word, an illegal flag and an error code.
REQ-036 The FSM, address, counter and error registers SHALL live in inst_assembler.

Verification
REQ-037 After reset, load_base=0x100 then I-ALU rd=1 rs1=0 f3=0 imm=5 SHALL give mem_we at addr 0x100 with wdata 0x00500093, and word_count=1.
REQ-038 BRANCH rs1=1 rs2=2 f3=0 imm=-8 SHALL give wdata 0xFE208CE3; JAL rd=1 imm=2048 SHALL give wdata 0x001000EF.
REQ-039 STORE rs1=2 rs2=5 f3=2 imm=12, with mem_ready held low for 3 cycles, SHALL give mem_we held 4 cycles, wdata 0x00512623 stable throughout, and mem_addr then advancing by 4.
REQ-040 BRANCH imm=3 SHALL give err=1, err_code=2 and no mem_we; a following I-ALU imm=4096 SHALL leave err_code at 2.
REQ-041 load_start asserted mid-WRITE with load_base=0x200 SHALL drop mem_we next cycle and give mem_addr=0x200, word_count=0, err=0.
REQ-042 load_base=0xFFFFFFFC plus two legal writes SHALL give mem_addr values 0xFFFFFFFC then 0x00000000.
